// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and bus-packing helpers for the register file.
//   Holds the default width/count localparams and the index helper used to
//   address one port's slice inside a flattened multi-port bus.
package regfile_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NREGS    = 16;
  localparam int RF_ADDR_W   = $clog2(RF_NREGS);
  localparam int RF_NRD      = 2;
  localparam int RF_NWR      = 2;
  localparam int RF_INSTR_W  = 16;
  localparam int RF_ZERO_REG = 1;

  // LSB position of port 'port' in a bus packed as port p at [p*width +: width].
  function automatic int unsigned slice_lsb(input int unsigned port,
                                            input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// regfile_core: storage array with multi-port priority write and an
// optional hard-wired zero register. Reads are purely combinational.
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   wr_en/addr/data     NWR packed write ports, highest index wins a conflict
//   rd_addr             NRD packed read addresses
//   rd_data_comb        NRD packed combinational read data (pre-write contents)
module regfile_core
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = RF_NRD,
  parameter int NWR      = RF_NWR,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data_comb
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Ports are applied in ascending order, so the last (highest-index)
  // non-blocking assignment to a shared address is the one that sticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] &&
            !((ZERO_REG != 0) && (wr_addr[slice_lsb(p, ADDR_W) +: ADDR_W] == '0))) begin
          r_mem[wr_addr[slice_lsb(p, ADDR_W) +: ADDR_W]] <=
            wr_data[slice_lsb(p, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rd_data_comb = '0;
    for (int r = 0; r < NRD; r++) begin
      if ((ZERO_REG != 0) && (rd_addr[slice_lsb(r, ADDR_W) +: ADDR_W] == '0))
        rd_data_comb[slice_lsb(r, DATA_W) +: DATA_W] = '0;
      else
        rd_data_comb[slice_lsb(r, DATA_W) +: DATA_W] =
          r_mem[rd_addr[slice_lsb(r, ADDR_W) +: ADDR_W]];
    end
  end

endmodule

// File: rtl/pipelined_register_file.sv
// pipelined_register_file: multi-port register file plus the decode/operand
// stage register feeding execute.
// Build option: define PIPELINED_REGISTER_FILE_BYPASS_EN to forward same-cycle
//   write data into the read operands (highest-index matching port wins,
//   address 0 never bypassed when ZERO_REG=1).
// Ports:
//   clk, reset            clock, async active-low reset
//   stall, flush          hold output stage / kill instruction entering it
//   in_valid + tags       instruction_in, cond_in, ls_in, rd_addr
//   wr_en/addr/data       write-back and forwarding write ports
//   rd_data, rd_addr_out  registered operands and their addresses
//   instruction_out, cond_out, ls_out, out_valid  registered stage outputs
// Flow control: the stage advances on every edge where stall=0; out_valid
//   then becomes in_valid & ~flush. With stall=1 every stage output holds and
//   flush is ignored. Payload is only captured on an advancing edge with
//   in_valid=1; otherwise it keeps its old value.
module pipelined_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = RF_NRD,
  parameter int NWR      = RF_NWR,
  parameter int INSTR_W  = RF_INSTR_W,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    instruction_in,
  input  logic                  cond_in,
  input  logic                  ls_in,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD*ADDR_W-1:0] rd_addr_out,
  output logic [INSTR_W-1:0]    instruction_out,
  output logic                  cond_out,
  output logic                  ls_out,
  output logic                  out_valid
);

  logic [NRD*DATA_W-1:0] w_core_rd;
  logic [NRD*DATA_W-1:0] w_operand;

  logic [NRD*DATA_W-1:0] r_rd_data;
  logic [NRD*ADDR_W-1:0] r_rd_addr;
  logic [INSTR_W-1:0]    r_instr;
  logic                  r_cond;
  logic                  r_ls;
  logic                  r_valid;

  regfile_core #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .ADDR_W  (ADDR_W),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_REG(ZERO_REG)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data_comb(w_core_rd)
  );

`ifdef PIPELINED_REGISTER_FILE_BYPASS_EN
  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    w_operand = w_core_rd;
    for (int r = 0; r < NRD; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] &&
            (wr_addr[slice_lsb(p, ADDR_W) +: ADDR_W] ==
             rd_addr[slice_lsb(r, ADDR_W) +: ADDR_W]) &&
            !((ZERO_REG != 0) && (rd_addr[slice_lsb(r, ADDR_W) +: ADDR_W] == '0))) begin
          w_operand[slice_lsb(r, DATA_W) +: DATA_W] =
            wr_data[slice_lsb(p, DATA_W) +: DATA_W];
        end
      end
    end
  end
`else
  assign w_operand = w_core_rd;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
      r_rd_addr <= '0;
      r_instr   <= '0;
      r_cond    <= 1'b0;
      r_ls      <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid & ~flush;
      if (in_valid) begin
        r_rd_data <= w_operand;
        r_rd_addr <= rd_addr;
        r_instr   <= instruction_in;
        r_cond    <= cond_in;
        r_ls      <= ls_in;
      end
    end
  end

  assign rd_data         = r_rd_data;
  assign rd_addr_out     = r_rd_addr;
  assign instruction_out = r_instr;
  assign cond_out        = r_cond;
  assign ls_out          = r_ls;
  assign out_valid       = r_valid;

endmodule

// File: tb/tb_pipelined_register_file.sv
module tb_pipelined_register_file;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int EW = 2*DW + 2*AW + 16 + 2;  // {rd_data, rd_addr, instr, cond, ls}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            stall, flush, in_valid, cond_in, ls_in;
  logic [15:0]     instruction_in;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*DW-1:0] rd_data;
  logic [2*AW-1:0] rd_addr_out;
  logic [15:0]     instruction_out;
  logic            cond_out, ls_out, out_valid;

  pipelined_register_file dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instruction_in(instruction_in), .cond_in(cond_in), .ls_in(ls_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_addr_out(rd_addr_out), .instruction_out(instruction_out),
    .cond_out(cond_out), .ls_out(ls_out), .out_valid(out_valid)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic          exp_valid;
  logic [DW-1:0] mdl [NR];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, "_stage"}, 64'({rd_data, rd_addr_out, instruction_out, cond_out, ls_out}),
          64'(last_exp));
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a,
      input logic [1:0] we, input logic [2*AW-1:0] wa, input logic [2*DW-1:0] wd);
    logic [DW-1:0] v;
    v = (a == '0) ? '0 : mdl[a];
`ifdef PIPELINED_REGISTER_FILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (we[p] && wa[p*AW +: AW] == a && a != '0) v = wd[p*DW +: DW];
`else
    if (we == 2'b11 && wa == 8'hFF && wd == 32'hFFFF_FFFF) v = v;  // no forwarding
`endif
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic st, input logic fl, input logic vl,
                      input logic [15:0] ins, input logic cd, input logic lsv,
                      input logic [1:0] we, input logic [2*AW-1:0] wa,
                      input logic [2*DW-1:0] wd, input logic [2*AW-1:0] ra);
    logic [EW-1:0] e;
    @(negedge clk);
    stall = st; flush = fl; in_valid = vl; instruction_in = ins; cond_in = cd;
    ls_in = lsv; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    e = {model_read(ra[AW +: AW], we, wa, wd), model_read(ra[0 +: AW], we, wa, wd),
         ra, ins, cd, lsv};
    if (!st && vl) exp_q.push_back(e);
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      if (we[p] && wa[p*AW +: AW] != '0) mdl[wa[p*AW +: AW]] = wd[p*DW +: DW];
    if (!st) begin
      exp_valid = vl & ~fl;
      if (vl) last_exp = exp_q.pop_front();
    end
    check_outputs(tag);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    step(tag, 0, 0, 1, 16'h00C0 ^ {8'h0, a1, a0}, a0[0], a1[0], 2'b00, '0, '0, {a1, a0});
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    last_exp = '0;
    exp_valid = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stall = 0; flush = 0; in_valid = 0; instruction_in = '0; cond_in = 0; ls_in = 0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset();
    #12;
    check_outputs("in_reset");
    @(negedge clk);
    reset = 1'b1;

    // all registers read zero after reset
    for (int i = 0; i < 8; i++) rd("rd_after_reset", AW'(2*i+1), AW'(2*i));

    // write conflict: highest port wins
    step("wr_conflict", 0, 0, 0, 16'h0, 0, 0, 2'b11, {4'd3, 4'd3}, {16'hBEEF, 16'h1234}, '0);
    rd("rd_conflict", 4'd3, 4'd3);
    check("conflict_value", 64'(rd_data[DW-1:0]), 64'h0000_0000_0000_BEEF);

    // same-cycle write/read of r5 (old value without bypass, new with)
    step("wr_rd_same", 0, 0, 1, 16'h5555, 1, 0, 2'b01, {4'd0, 4'd5}, {16'h0, 16'h00AA},
         {4'd5, 4'd5});
    rd("rd_r5", 4'd5, 4'd0);

    // zero register ignores writes
    step("wr_r0", 0, 0, 0, 16'h0, 0, 0, 2'b11, {4'd0, 4'd0}, {16'hFFFF, 16'hFFFF}, '0);
    rd("rd_r0", 4'd0, 4'd0);

    // stall holds the stage while the array still updates
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1, i == 1, 1, 16'hDEAD, 1, 1, 2'b01, {4'd0, 4'd7},
           {16'h0, 16'h0042}, {4'd7, 4'd6});
    rd("rd_r7", 4'd6, 4'd7);
    check("r7_value", 64'(rd_data[DW-1:0]), 64'h0000_0000_0000_0042);
    step("flush", 0, 1, 1, 16'hF00D, 0, 1, 2'b00, '0, '0, {4'd7, 4'd3});
    step("idle", 0, 0, 0, 16'hAAAA, 1, 1, 2'b00, '0, '0, {4'd1, 4'd1});

    // async reset mid-stream with a write in flight
    step("wr_r2", 0, 0, 0, 16'h0, 0, 0, 2'b01, {4'd0, 4'd2}, {16'h0, 16'h5555}, '0);
    rd("rd_r2_live", 4'd2, 4'd2);
    @(negedge clk);
    wr_en = 2'b10; wr_addr = {4'd9, 4'd0}; wr_data = {16'h1111, 16'h0}; in_valid = 1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("held_in_reset");
    @(negedge clk);
    wr_en = '0;
    reset = 1'b1;
    rd("rd_r2_after_reset", 4'd9, 4'd2);

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      logic [1:0] we;
      we = 2'($urandom_range(0, 3));
      step("random", $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 1'($urandom), we,
           8'($urandom), 32'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
